tdc_hit_readout: RTL

Receive-side readout for the TDC pulse-generator controller, in the clk320 domain. It takes the controller's asynchronous write strobes (RawdataWrtClk, EncdataWrtClk, ResetFlag) and the encoder's TOA/TOT/CAL codes. From these it builds one time-stamped event word per hit and buffers it in a small first-word-fall-through FIFO, which drains downstream over a valid/ready handshake. It also keeps a bunch-crossing counter, checks that strobes arrive in the right order, and reports drops caused by the FIFO being full.

---
 rtl/tdc_hit_readout.sv | 351 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tdc_hit_readout.sv
`default_nettype none
// ============================================================================
// Module   : tdc_hit_readout
// Purpose  : clk320-domain receive-side readout for the TDC pulse-generator
//            controller. It synchronises the controller's asynchronous write
//            strobes and pairs each raw strobe with its encoder strobe. Each
//            hit becomes one time-stamped event word, held in a registered
//            first-word-fall-through FIFO that drains over valid/ready.
//            A bunch-crossing counter, a strobe-ordering check, and drop and
//            hit counters are also maintained here.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk320        in   320 MHz clock
//   RESETN1       in   asynchronous active-low reset
//   bc_strobe     in   one-cycle pulse per bunch crossing (synchronous)
//   bc_reset      in   synchronous BCID clear, wins over bc_strobe
//   raw_wr        in   RawdataWrtClk (asynchronous)
//   enc_wr        in   EncdataWrtClk (asynchronous)
//   reset_flag_n  in   ResetFlag, active-low (asynchronous)
//   toa/tot/cal_code in  encoder codes, stable while enc_wr is high
//   dout          out  event word {[parity], err, bcid, toa, tot, cal}
//   dout_valid    out  dout holds a word
//   dout_ready    in   downstream accepts the word
//   fifo_full     out  FIFO occupancy equals DEPTH
//   ovf_cnt       out  dropped-word counter, saturates at 255
//   hit_cnt       out  pushed-word counter, wraps
// Error codes: 00 normal, 01 encoder timeout, 10 orphan encoder strobe,
//              11 aborted by ResetFlag
// Build option: define TDC_READOUT_PARITY_EN to prepend an even-parity MSB
// ============================================================================
module tdc_hit_readout #(
    parameter int TOA_W  = 10,
    parameter int TOT_W  = 9,
    parameter int CAL_W  = 10,
    parameter int BCID_W = 12,
    parameter int BC_MAX = 3563,
    parameter int DEPTH  = 8,
    parameter int TMO    = 15,
`ifdef TDC_READOUT_PARITY_EN
    localparam int c_PAR_W = 1,
`else
    localparam int c_PAR_W = 0,
`endif
    localparam int c_W = BCID_W + TOA_W + TOT_W + CAL_W + 2 + c_PAR_W
) (
    input  logic              clk320,
    input  logic              RESETN1,
    input  logic              bc_strobe,
    input  logic              bc_reset,
    input  logic              raw_wr,
    input  logic              enc_wr,
    input  logic              reset_flag_n,
    input  logic [TOA_W-1:0]  toa_code,
    input  logic [TOT_W-1:0]  tot_code,
    input  logic [CAL_W-1:0]  cal_code,
    output logic [c_W-1:0]    dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              fifo_full,
    output logic [7:0]        ovf_cnt,
    output logic [15:0]       hit_cnt
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam int              c_CW       = c_AW + 1;
    localparam int              c_BASE_W   = c_W - c_PAR_W;
    localparam logic [BCID_W-1:0] c_BC_MAX = BCID_W'(BC_MAX);
    localparam logic [3:0]      c_TMO      = 4'(TMO);
    localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ENC = 2'd1,
        S_WRITE    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Strobe synchronisers: [0] first stage, [1] synchronised value,
    // [2] one-cycle history for edge detection.
    // ------------------------------------------------------------------
    logic [2:0] r_raw_sync;
    logic [2:0] r_enc_sync;
    logic [2:0] r_rf_sync;
    logic [1:0] r_warm;

    always_ff @(posedge clk320 or negedge RESETN1) begin
        if (!RESETN1) begin
            r_raw_sync <= '0;
            r_enc_sync <= '0;
            r_rf_sync  <= '0;
            r_warm     <= '0;
        end else begin
            r_raw_sync <= {r_raw_sync[1:0], raw_wr};
            r_enc_sync <= {r_enc_sync[1:0], enc_wr};
            r_rf_sync  <= {r_rf_sync[1:0], reset_flag_n};
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
        end
    end

    // Edges are ignored until all three stages hold real input samples, so
    // a strobe that is already high (or ResetFlag already high) when reset
    // releases is not mistaken for a fresh transition.
    logic w_edge_en;
    logic w_raw_re;
    logic w_enc_re;
    logic w_rf_fe;

    assign w_edge_en = (r_warm == 2'd3);
    assign w_raw_re  = w_edge_en &  r_raw_sync[1] & ~r_raw_sync[2];
    assign w_enc_re  = w_edge_en &  r_enc_sync[1] & ~r_enc_sync[2];
    assign w_rf_fe   = w_edge_en & ~r_rf_sync[1]  &  r_rf_sync[2];

    // ------------------------------------------------------------------
    // Bunch-crossing counter
    // ------------------------------------------------------------------
    logic [BCID_W-1:0] r_bcid;

    always_ff @(posedge clk320 or negedge RESETN1) begin
        if (!RESETN1) begin
            r_bcid <= '0;
        end else if (bc_reset) begin
            r_bcid <= '0;
        end else if (bc_strobe) begin
            r_bcid <= (r_bcid == c_BC_MAX) ? '0 : r_bcid + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Event-building FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_n;
    logic   [3:0] r_timer;
    logic   w_timer_clr;
    logic   w_bcid_ld;
    logic   w_cap_codes;
    logic   w_zero_codes;
    logic   w_err_ld;
    logic   [1:0] w_err_n;

    always_ff @(posedge clk320 or negedge RESETN1) begin
        if (!RESETN1) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_timer_clr  = 1'b0;
        w_bcid_ld    = 1'b0;
        w_cap_codes  = 1'b0;
        w_zero_codes = 1'b0;
        w_err_ld     = 1'b0;
        w_err_n      = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (w_raw_re && w_enc_re) begin
                    // Both strobes resolved in the same cycle: still a
                    // properly ordered hit, so build it directly.
                    w_state_n   = S_WRITE;
                    w_bcid_ld   = 1'b1;
                    w_cap_codes = 1'b1;
                    w_err_ld    = 1'b1;
                    w_err_n     = 2'b00;
                end else if (w_raw_re) begin
                    w_state_n   = S_WAIT_ENC;
                    w_timer_clr = 1'b1;
                    w_bcid_ld   = 1'b1;
                end else if (w_enc_re) begin
                    w_state_n   = S_WRITE;
                    w_bcid_ld   = 1'b1;
                    w_cap_codes = 1'b1;
                    w_err_ld    = 1'b1;
                    w_err_n     = 2'b10;
                end
            end
            S_WAIT_ENC: begin
                if (w_enc_re) begin
                    w_state_n   = S_WRITE;
                    w_cap_codes = 1'b1;
                    w_err_ld    = 1'b1;
                    w_err_n     = 2'b00;
                end else if (w_rf_fe) begin
                    w_state_n    = S_WRITE;
                    w_zero_codes = 1'b1;
                    w_err_ld     = 1'b1;
                    w_err_n      = 2'b11;
                end else if (r_timer == c_TMO) begin
                    w_state_n    = S_WRITE;
                    w_zero_codes = 1'b1;
                    w_err_ld     = 1'b1;
                    w_err_n      = 2'b01;
                end
            end
            S_WRITE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Timer counts cycles spent waiting for the encoder strobe.
    always_ff @(posedge clk320 or negedge RESETN1) begin
        if (!RESETN1) begin
            r_timer <= '0;
        end else if (w_timer_clr) begin
            r_timer <= '0;
        end else if (r_state == S_WAIT_ENC && r_timer != c_TMO) begin
            r_timer <= r_timer + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Event fields
    // ------------------------------------------------------------------
    logic [1:0]        r_err;
    logic [BCID_W-1:0] r_bcid_lat;
    logic [TOA_W-1:0]  r_toa;
    logic [TOT_W-1:0]  r_tot;
    logic [CAL_W-1:0]  r_cal;

    always_ff @(posedge clk320 or negedge RESETN1) begin
        if (!RESETN1) begin
            r_err      <= '0;
            r_bcid_lat <= '0;
            r_toa      <= '0;
            r_tot      <= '0;
            r_cal      <= '0;
        end else begin
            if (w_err_ld) begin
                r_err <= w_err_n;
            end
            if (w_bcid_ld) begin
                r_bcid_lat <= r_bcid;
            end
            if (w_cap_codes) begin
                r_toa <= toa_code;
                r_tot <= tot_code;
                r_cal <= cal_code;
            end else if (w_zero_codes) begin
                r_toa <= '0;
                r_tot <= '0;
                r_cal <= '0;
            end
        end
    end

    logic [c_BASE_W-1:0] w_base;
    logic [c_W-1:0]      w_word;

    assign w_base = {r_err, r_bcid_lat, r_toa, r_tot, r_cal};
`ifdef TDC_READOUT_PARITY_EN
    // Even parity: the XOR over the whole word comes out zero.
    assign w_word = {^w_base, w_base};
`else
    assign w_word = w_base;
`endif

    // ------------------------------------------------------------------
    // FWFT FIFO. dout is a registered copy of the head entry, so the head
    // slot in r_mem may be overwritten when a push and a pop hit a full
    // FIFO in the same cycle.
    // ------------------------------------------------------------------
    logic [c_W-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_accept;
    logic            w_drop;
    logic [c_AW-1:0] w_rd_ptr_n;
    logic [c_CW-1:0] w_count_n;
    logic [c_CW-1:0] w_remain;
    logic            w_head_new;

    assign w_push     = (r_state == S_WRITE);
    assign w_pop      = dout_valid & dout_ready;
    assign w_accept   = w_push & ((r_count != c_DEPTH) | w_pop);
    assign w_drop     = w_push & ~w_accept;
    assign w_rd_ptr_n = w_pop ? r_rd_ptr + c_AW'(1) : r_rd_ptr;
    assign w_remain   = w_pop ? r_count - c_CW'(1) : r_count;
    // Head comes from the incoming word only when nothing older remains.
    assign w_head_new = (w_remain == '0);

    always_comb begin
        w_count_n = r_count;
        if (w_accept && !w_pop) begin
            w_count_n = r_count + c_CW'(1);
        end else if (!w_accept && w_pop) begin
            w_count_n = r_count - c_CW'(1);
        end
    end

    always_ff @(posedge clk320) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk320 or negedge RESETN1) begin
        if (!RESETN1) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            fifo_full  <= 1'b0;
        end else begin
            r_count  <= w_count_n;
            r_rd_ptr <= w_rd_ptr_n;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            // dout only moves when the head is consumed or the FIFO was
            // empty, which keeps it stable during a stalled handshake.
            if ((w_pop || r_count == '0) && w_count_n != '0) begin
                dout <= w_head_new ? w_word : r_mem[w_rd_ptr_n];
            end
            dout_valid <= (w_count_n != '0);
            fifo_full  <= (w_count_n == c_DEPTH);
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk320 or negedge RESETN1) begin
        if (!RESETN1) begin
            hit_cnt <= '0;
            ovf_cnt <= '0;
        end else begin
            if (w_push) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (w_drop && ovf_cnt != 8'hFF) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
